// File: rtl/axi4_lite_pkg.sv
// ---------------------------------------------------------------------------
// | Module  : axi4_lite_pkg                                                 |
// | Brief   : Shared types, register offsets and helpers for the AXI4-Lite  |
// |           I/O slave.                                                    |
// | Revision: 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

package axi4_lite_pkg;

  // AXI response codes used by this slave
  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  // Register byte offsets
  localparam logic [4:0] LED_OFS       = 5'h00;
  localparam logic [4:0] SEG_OFS       = 5'h04;
  localparam logic [4:0] IRQ_EN_OFS    = 5'h08;
  localparam logic [4:0] IRQ_STAT_OFS  = 5'h0C;
  localparam logic [4:0] TMR_LOAD_OFS  = 5'h10;
  localparam logic [4:0] TMR_CTRL_OFS  = 5'h14;
  localparam logic [4:0] TMR_COUNT_OFS = 5'h18;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Merge new data into an old word, byte lane by byte lane
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi4_lite_io_slave_if.sv
// ---------------------------------------------------------------------------
// | Module  : axi4_lite_io_slave_if                                         |
// | Brief   : AXI4-Lite five-channel bundle with master/slave views.        |
// | Revision: 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

interface axi4_lite_io_slave_if
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] S_AWADDR;
  logic                  S_AWVALID;
  logic                  S_AWREADY;
  logic [DATA_WIDTH-1:0] S_WDATA;
  logic [3:0]            S_WSTRB;
  logic                  S_WVALID;
  logic                  S_WREADY;
  logic                  S_BREADY;
  logic                  S_BVALID;
  resp_t                 S_BRESP;
  logic [ADDR_WIDTH-1:0] S_ARADDR;
  logic                  S_ARVALID;
  logic                  S_ARREADY;
  logic                  S_RREADY;
  logic [DATA_WIDTH-1:0] S_RDATA;
  logic                  S_RVALID;
  resp_t                 S_RRESP;

  modport master (
    output S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
           S_ARADDR, S_ARVALID, S_RREADY,
    input  S_AWREADY, S_WREADY, S_BVALID, S_BRESP,
           S_ARREADY, S_RDATA, S_RVALID, S_RRESP
  );

  modport slave (
    input  S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
           S_ARADDR, S_ARVALID, S_RREADY,
    output S_AWREADY, S_WREADY, S_BVALID, S_BRESP,
           S_ARREADY, S_RDATA, S_RVALID, S_RRESP
  );

endinterface

`default_nettype wire

// File: rtl/axi_timer_core.sv
// ---------------------------------------------------------------------------
// | Module  : axi_timer_core                                                |
// | Brief   : 32-bit down-counter with optional autoreload and a one-cycle  |
// |           fire pulse when the count expires.                            |
// | Revision: 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

module axi_timer_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_we_i,
  input  logic [31:0] load_val_i,
  input  logic        enable_i,
  input  logic        autoreload_i,
  output logic [31:0] count_o,
  output logic        fire_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] reload_q, reload_d;

  // A fresh load takes priority over expiry in the same cycle
  assign fire_o  = enable_i && !load_we_i && (count_q == 32'd1);
  assign count_o = count_q;

  // Next count: load, then decrement/expire; a zero count is idle
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    if (load_we_i) begin
      count_d  = load_val_i;
      reload_d = load_val_i;
    end else if (enable_i && (count_q != 32'd0)) begin
      if (fire_o) count_d = autoreload_i ? reload_q : 32'd0;
      else        count_d = count_q - 32'd1;
    end
  end

  // Counter and reload value registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= 32'd0;
      reload_q <= 32'd0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/axi4_lite_io_slave.sv
// ---------------------------------------------------------------------------
// | Module  : axi4_lite_io_slave                                            |
// | Brief   : AXI4-Lite register slave driving LEDs, seven-segment and an   |
// |           interrupt from a down-counting timer.                         |
// | Revision: 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

module axi4_lite_io_slave
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  axi4_lite_io_slave_if.slave  s,
  output logic [7:0]           LED_OUT,
  output logic [7:0]           SEVENSEG_OUT,
  output logic                 IRQ_OUT
);

  wr_state_t wr_state_q, wr_state_d;
  rd_state_t rd_state_q, rd_state_d;

  logic                  aw_held_q, w_held_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            wstrb_q;
  resp_t                 bresp_q, rresp_q;
  logic [31:0]           rdata_q;

  logic [7:0]  led_q, seg_q;
  logic        irq_en_q, irq_stat_q;
  logic [31:0] tmr_load_q;
  logic [1:0]  tmr_ctrl_q;

  logic        w_awready, w_wready, w_arready;
  logic        w_aw_hs, w_w_hs, w_ar_hs;
  logic        w_commit, w_b_done;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [31:0] w_wr_data;
  logic [3:0]  w_wr_strb;
  logic [2:0]  w_wr_idx, w_rd_idx;
  logic        w_wr_ok, w_rd_ok;
  logic [31:0] w_rd_mux;
  logic        w_load_we;
  logic [31:0] w_load_val;
  logic [31:0] w_tmr_count;
  logic        w_tmr_fire;
  logic        unused_addr_lsbs;

  // Only the 32-byte window at address zero is decoded
  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
    return (a >> 5) == '0;
  endfunction

  // Byte-offset bits never select anything
  assign unused_addr_lsbs = ^{w_wr_addr[1:0], s.S_ARADDR[1:0]};

  // The write may complete on the same edge as the last handshake, so
  // the beat being presented is used directly when not yet latched
  assign w_wr_addr = aw_held_q ? awaddr_q : s.S_AWADDR;
  assign w_wr_data = w_held_q  ? wdata_q  : s.S_WDATA;
  assign w_wr_strb = w_held_q  ? wstrb_q  : s.S_WSTRB;
  assign w_wr_idx  = w_wr_addr[4:2];
  assign w_wr_ok   = in_window(w_wr_addr) && (w_wr_idx <= TMR_CTRL_OFS[4:2]);

  assign w_aw_hs = s.S_AWVALID & w_awready;
  assign w_w_hs  = s.S_WVALID  & w_wready;

  // Write FSM next state and channel readies
  always_comb begin
    wr_state_d = wr_state_q;
    w_awready  = 1'b0;
    w_wready   = 1'b0;
    w_commit   = 1'b0;
    w_b_done   = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        w_awready = !aw_held_q;
        w_wready  = !w_held_q;
        if ((aw_held_q || s.S_AWVALID) && (w_held_q || s.S_WVALID)) begin
          w_commit   = 1'b1;
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s.S_BREADY) begin
          w_b_done   = 1'b1;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Write FSM state register
  always_ff @(posedge ACLK) begin
    if (ARESET) wr_state_q <= W_IDLE;
    else        wr_state_q <= wr_state_d;
  end

  // AW/W latches and write response
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= OKAY;
    end else begin
      if (w_aw_hs) begin
        aw_held_q <= 1'b1;
        awaddr_q  <= s.S_AWADDR;
      end
      if (w_w_hs) begin
        w_held_q <= 1'b1;
        wdata_q  <= s.S_WDATA;
        wstrb_q  <= s.S_WSTRB;
      end
      if (w_commit) bresp_q <= w_wr_ok ? OKAY : SLVERR;
      if (w_b_done) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
      end
    end
  end

  assign w_load_we  = w_commit && w_wr_ok && (w_wr_idx == TMR_LOAD_OFS[4:2]);
  assign w_load_val = apply_wstrb(tmr_load_q, w_wr_data, w_wr_strb);

  // Register file; a timer expiry beats a simultaneous W1C clear
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      led_q      <= 8'd0;
      seg_q      <= 8'd0;
      irq_en_q   <= 1'b0;
      irq_stat_q <= 1'b0;
      tmr_load_q <= 32'd0;
      tmr_ctrl_q <= 2'd0;
    end else begin
      if (w_commit && w_wr_ok && w_wr_strb[0]) begin
        case (w_wr_idx)
          LED_OFS[4:2]:      led_q      <= w_wr_data[7:0];
          SEG_OFS[4:2]:      seg_q      <= w_wr_data[7:0];
          IRQ_EN_OFS[4:2]:   irq_en_q   <= w_wr_data[0];
          TMR_CTRL_OFS[4:2]: tmr_ctrl_q <= w_wr_data[1:0];
          default: ;
        endcase
      end
      if (w_load_we) tmr_load_q <= w_load_val;
      if (w_tmr_fire) begin
        irq_stat_q <= 1'b1;
      end else if (w_commit && w_wr_ok && (w_wr_idx == IRQ_STAT_OFS[4:2]) &&
                   w_wr_strb[0] && w_wr_data[0]) begin
        irq_stat_q <= 1'b0;
      end
    end
  end

  axi_timer_core u_timer (
    .clk          (ACLK),
    .rst          (ARESET),
    .load_we_i    (w_load_we),
    .load_val_i   (w_load_val),
    .enable_i     (tmr_ctrl_q[0]),
    .autoreload_i (tmr_ctrl_q[1]),
    .count_o      (w_tmr_count),
    .fire_o       (w_tmr_fire)
  );

  assign w_rd_idx = s.S_ARADDR[4:2];
  assign w_rd_ok  = in_window(s.S_ARADDR) && (w_rd_idx != 3'd7);

  // Read data mux; unimplemented bits read as zero
  always_comb begin
    w_rd_mux = 32'd0;
    case (w_rd_idx)
      LED_OFS[4:2]:       w_rd_mux = {24'd0, led_q};
      SEG_OFS[4:2]:       w_rd_mux = {24'd0, seg_q};
      IRQ_EN_OFS[4:2]:    w_rd_mux = {31'd0, irq_en_q};
      IRQ_STAT_OFS[4:2]:  w_rd_mux = {31'd0, irq_stat_q};
      TMR_LOAD_OFS[4:2]:  w_rd_mux = tmr_load_q;
      TMR_CTRL_OFS[4:2]:  w_rd_mux = {30'd0, tmr_ctrl_q};
      TMR_COUNT_OFS[4:2]: w_rd_mux = w_tmr_count;
      default:            w_rd_mux = 32'd0;
    endcase
    if (!w_rd_ok) w_rd_mux = 32'd0;
  end

  // Read FSM next state and ARREADY
  always_comb begin
    rd_state_d = rd_state_q;
    w_arready  = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        w_arready = 1'b1;
        if (s.S_ARVALID) rd_state_d = R_DATA;
      end
      R_DATA: begin
        if (s.S_RREADY) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  assign w_ar_hs = s.S_ARVALID & w_arready;

  // Read FSM state register
  always_ff @(posedge ACLK) begin
    if (ARESET) rd_state_q <= R_IDLE;
    else        rd_state_q <= rd_state_d;
  end

  // Read data is captured at the AR handshake and held until accepted
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rdata_q <= 32'd0;
      rresp_q <= OKAY;
    end else if (w_ar_hs) begin
      rdata_q <= w_rd_mux;
      rresp_q <= w_rd_ok ? OKAY : SLVERR;
    end
  end

  assign s.S_AWREADY = w_awready;
  assign s.S_WREADY  = w_wready;
  assign s.S_BVALID  = (wr_state_q == W_RESP);
  assign s.S_BRESP   = bresp_q;
  assign s.S_ARREADY = w_arready;
  assign s.S_RVALID  = (rd_state_q == R_DATA);
  assign s.S_RDATA   = rdata_q;
  assign s.S_RRESP   = rresp_q;

  assign LED_OUT      = led_q;
  assign SEVENSEG_OUT = seg_q;
  assign IRQ_OUT      = irq_stat_q & irq_en_q;

endmodule

`default_nettype wire
